// File: rtl/sand_brush.sv
// Brush painter: clips a square box around the brush centre and walks it row-major, writing particle cells.
// Define SAND_BRUSH_ROUND_EN for a round brush (dx*dx+dy*dy <= r*r); the default build paints the whole square box.
module sand_brush #(
  parameter int GRID_W = 160,
  parameter int GRID_H = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [7:0]        cmd_radius,
  input  logic [1:0]        cmd_type,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

  localparam logic signed [9:0] X_MAX = 10'(GRID_W - 1);
  localparam logic signed [9:0] Y_MAX = 10'(GRID_H - 1);

  function automatic logic signed [9:0] clamp_lo(input logic signed [9:0] v);
    return (v < 0) ? 10'sd0 : v;
  endfunction

  function automatic logic signed [9:0] clamp_hi(input logic signed [9:0] v,
                                                 input logic signed [9:0] hi);
    return (v > hi) ? hi : v;
  endfunction

`ifdef SAND_BRUSH_ROUND_EN
  function automatic logic in_round(input logic [7:0] px, input logic [7:0] py,
                                    input logic [7:0] ox, input logic [7:0] oy,
                                    input logic [7:0] rad);
    logic signed [9:0]  dx, dy;
    logic signed [16:0] dx2, dy2;
    logic [16:0]        d2;
    logic [15:0]        r2;
    dx  = $signed({2'b00, px}) - $signed({2'b00, ox});
    dy  = $signed({2'b00, py}) - $signed({2'b00, oy});
    dx2 = 17'(dx) * 17'(dx);
    dy2 = 17'(dy) * 17'(dy);
    d2  = $unsigned(dx2) + $unsigned(dy2);
    r2  = 16'(rad) * 16'(rad);
    return d2 <= {1'b0, r2};
  endfunction
`endif

  state_t            state_q, state_d;
  logic [7:0]        x_q, x_d, y_q, y_d, r_q, r_d;
  logic [1:0]        type_q, type_d;
  logic [7:0]        cx_q, cx_d, cy_q, cy_d;
  logic [7:0]        x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        mem_data_q, mem_data_d;

  logic signed [9:0] bx0, bx1, by0, by1;
  logic [7:0]        nx, ny;
  logic              load, in_next;

  always_comb begin
    bx0 = clamp_lo($signed({2'b00, x_q}) - $signed({2'b00, r_q}));
    bx1 = clamp_hi($signed({2'b00, x_q}) + $signed({2'b00, r_q}), X_MAX);
    by0 = clamp_lo($signed({2'b00, y_q}) - $signed({2'b00, r_q}));
    by1 = clamp_hi($signed({2'b00, y_q}) + $signed({2'b00, r_q}), Y_MAX);

    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    r_d        = r_q;
    type_d     = type_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    nx         = cx_q;
    ny         = cy_q;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          r_d     = cmd_radius;
          type_d  = cmd_type;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if ((bx0 > bx1) || (by0 > by1)) begin
          state_d = DONE;
        end else begin
          state_d = SCAN;
          x0_d    = bx0[7:0];
          x1_d    = bx1[7:0];
          y1_d    = by1[7:0];
          nx      = bx0[7:0];
          ny      = by0[7:0];
          load    = 1'b1;
        end
      end
      SCAN: begin
        // A pending write blocks the walk until the memory takes it.
        if (!mem_we_q || mem_ready) begin
          if ((cx_q == x1_q) && (cy_q == y1_q)) begin
            state_d  = DONE;
            mem_we_d = 1'b0;
          end else begin
            load = 1'b1;
            if (cx_q == x1_q) begin
              nx = x0_q;
              ny = cy_q + 8'd1;
            end else begin
              nx = cx_q + 8'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SAND_BRUSH_ROUND_EN
    in_next = in_round(nx, ny, x_q, y_q, r_q);
`else
    in_next = 1'b1;
`endif

    if (load) begin
      cx_d       = nx;
      cy_d       = ny;
      mem_we_d   = in_next;
      mem_addr_d = ADDR_W'(ny) * ADDR_W'(GRID_W) + ADDR_W'(nx);
      mem_data_d = type_q;
    end

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      r_q         <= '0;
      type_q      <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      r_q         <= r_d;
      type_q      <= type_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;

endmodule

// File: tb/tb_sand_brush.sv
// Bench for sand_brush: directed and random brush commands against a whole-grid reference painter.
module tb_sand_brush;

  localparam int GRID_W = 160;
  localparam int GRID_H = 120;
  localparam int ADDR_W = 15;

`ifdef SAND_BRUSH_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [7:0]        cmd_x, cmd_y, cmd_radius;
  logic [1:0]        cmd_type;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_data;
  logic              mem_we;
  logic              mem_ready;
  logic              busy;
  logic              done;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  sand_brush #(.GRID_W(GRID_W), .GRID_H(GRID_H), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_radius(cmd_radius), .cmd_type(cmd_type),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ready(mem_ready),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endfunction

  // Paint the whole grid by rule: box = cells within r of the centre on both axes, clipped by the grid.
  task automatic build_model(input int x, input int y, input int r, output int cells);
    exp_q.delete();
    cells = 0;
    for (int cy = 0; cy < GRID_H; cy++) begin
      for (int cx = 0; cx < GRID_W; cx++) begin
        int dx;
        int dy;
        dx = cx - x;
        dy = cy - y;
        if (dx >= -r && dx <= r && dy >= -r && dy <= r) begin
          cells++;
          if (!ROUND || (dx * dx + dy * dy <= r * r)) exp_q.push_back(cy * GRID_W + cx);
        end
      end
    end
  endtask

  // mode 0: memory always ready; 1: first write stalled 3 cycles; 2: random ready
  task automatic run_cmd(input int x, input int y, input int r, input int t, input int mode);
    int cells, k, wr_idx, stalls, done_k, first_stalls, limit;
    logic prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [1:0] prev_data;
    build_model(x, y, r, cells);
    @(negedge clock);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    cmd_x = 8'(x); cmd_y = 8'(y); cmd_radius = 8'(r); cmd_type = 2'(t);
    cmd_valid = 1'b1;
    mem_ready = 1'b1;
    @(negedge clock);
    k = 1; wr_idx = 0; stalls = 0; done_k = 0; first_stalls = 0;
    prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
    limit = 3 * cells + 40;
    while (done_k == 0 && k < limit) begin
      chk("busy", busy, 1);
      chk("no_ready_busy", cmd_ready, 0);
      if (prev_stall) begin
        chk("hold_we", mem_we, 1);
        chk("hold_addr", mem_addr, prev_addr);
        chk("hold_data", mem_data, prev_data);
      end
      if (done === 1'b1) begin
        done_k = k;
        cmd_valid = 1'b0;
      end else begin
        cmd_valid  = 1'($urandom_range(0, 1));
        cmd_x      = 8'($urandom);
        cmd_y      = 8'($urandom);
        cmd_radius = 8'($urandom);
        cmd_type   = 2'($urandom);
      end
      case (mode)
        1: begin
          if (mem_we === 1'b1 && wr_idx == 0 && first_stalls < 3) begin
            mem_ready = 1'b0;
            first_stalls++;
          end else begin
            mem_ready = 1'b1;
          end
        end
        2: mem_ready = ($urandom_range(0, 3) != 0);
        default: mem_ready = 1'b1;
      endcase
      if (mem_we === 1'b1) begin
        if (mem_ready) begin
          if (wr_idx < exp_q.size()) begin
            chk("wr_addr", mem_addr, exp_q[wr_idx]);
            chk("wr_data", mem_data, t);
          end else begin
            chk("extra_write", wr_idx, exp_q.size());
          end
          wr_idx++;
        end else begin
          stalls++;
        end
      end
      prev_stall = (mem_we === 1'b1) && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_data;
      @(negedge clock);
      k++;
    end
    mem_ready = 1'b1;
    cmd_valid = 1'b0;
    chk("done_seen", (done_k != 0), 1);
    chk("done_cycle", done_k, 2 + cells + stalls);
    chk("write_count", wr_idx, exp_q.size());
    if (mode == 1 && exp_q.size() > 0) chk("first_stall", first_stalls, 3);
    chk("done_pulse", done, 0);
    chk("ready_after", cmd_ready, 1);
    chk("busy_after", busy, 0);
    chk("we_after", mem_we, 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_data"}, mem_data, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cells, k, wr;
    reset = 1'b1; cmd_valid = 1'b0; mem_ready = 1'b1;
    cmd_x = '0; cmd_y = '0; cmd_radius = '0; cmd_type = '0;
    repeat (3) @(negedge clock);
    chk_idle_outputs("reset");
    reset = 1'b0;

    run_cmd(10, 10, 0, 2, 0);
    run_cmd(10, 10, 1, 1, 0);
    run_cmd(0, 0, 2, 3, 0);
    run_cmd(200, 50, 3, 1, 0);
    run_cmd(10, 10, 1, 1, 1);

    // Reset after the second write of a running command.
    build_model(10, 10, 1, cells);
    @(negedge clock);
    cmd_x = 8'd10; cmd_y = 8'd10; cmd_radius = 8'd1; cmd_type = 2'd3;
    cmd_valid = 1'b1; mem_ready = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    k = 1; wr = 0;
    while (wr < 2 && k < 40) begin
      if (mem_we === 1'b1) begin
        chk("rst_wr_addr", mem_addr, exp_q[wr]);
        wr++;
      end
      if (wr == 2) reset = 1'b1;
      @(negedge clock);
      k++;
    end
    chk("rst_reached", wr, 2);
    chk_idle_outputs("midrst");
    reset = 1'b0;
    repeat (6) begin
      @(negedge clock);
      chk("post_rst_we", mem_we, 0);
      chk("post_rst_done", done, 0);
      chk("post_rst_ready", cmd_ready, 1);
    end

    run_cmd(10, 10, 1, 2, 0);
    run_cmd(159, 119, 4, 1, 2);
    run_cmd(0, 119, 0, 3, 0);
    run_cmd(160, 10, 0, 1, 0);
    for (int i = 0; i < 12; i++) begin
      run_cmd(int'($urandom_range(0, 175)), int'($urandom_range(0, 135)),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sand_brush.md
SAND_BRUSH -- requirements
Module: sand_brush

Interface
REQ-001 SHALL have parameters: GRID_W, 160, grid width in cells; GRID_H, 120, grid height in cells; ADDR_W, 15, cell address width.
REQ-002 SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports cmd_x, cmd_y, cmd_radius  in  8 each  brush centre column, centre row and radius, unsigned.
REQ-005 SHALL have port cmd_type  in  2  particle type to paint.
REQ-006 SHALL have ports cmd_valid  in  1 and cmd_ready  out  1  command handshake.
REQ-007 SHALL have ports mem_addr  out  ADDR_W, mem_data  out  2, mem_we  out  1  grid write request; mem_ready  in  1  write accepted.
REQ-008 SHALL have ports busy  out  1 (command in progress) and done  out  1 (one-cycle completion pulse).

Function
REQ-009 SHALL implement states IDLE, SETUP, SCAN, DONE.
REQ-010 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a clock edge where cmd_valid && cmd_ready, latching all cmd_* fields, and the state goes to SETUP.
REQ-011 SETUP (one cycle) SHALL compute a clipped box in 10-bit signed arithmetic: x0=max(x-r,0), x1=min(x+r,GRID_W-1), y0=max(y-r,0), y1=min(y+r,GRID_H-1).
REQ-012 If x0>x1 or y0>y1 (empty box, e.g. centre far outside grid), SETUP SHALL go to DONE with no writes; otherwise it SHALL go to SCAN at (x0,y0).
REQ-013 SCAN SHALL visit one candidate cell per step in row-major order (x fastest), from (x0,y0) to (x1,y1).
REQ-014 mem_we SHALL be 1 in SCAN when the candidate is inside the brush; mem_addr=cy*GRID_W+cx; mem_data=latched cmd_type.
REQ-015 Scan SHALL advance when mem_we==0 or mem_ready==1; while mem_we==1 && mem_ready==0, mem_addr, mem_data and mem_we SHALL hold.
REQ-016 After the step at (x1,y1) completes, state SHALL go to DONE; DONE asserts done for exactly one cycle, then goes to IDLE.
REQ-017 busy SHALL be 1 in SETUP, SCAN and DONE.
REQ-018 Radius 0 SHALL paint exactly the centre cell, if it lies in the grid.
REQ-019 cmd_valid asserted outside IDLE SHALL be ignored; a command SHALL be accepted in the cycle after DONE at the earliest.
REQ-020 Latency with mem_ready=1: accept edge N, SETUP cycle N+1, first candidate N+2, done in cycle N+2+box_cells.
REQ-021 Outputs SHALL depend only on registered state (no combinational path from mem_ready or cmd_* to any output).

Reset
REQ-022 On reset the state SHALL go to IDLE: cmd_ready=1, busy=0, done=0, mem_we=0, mem_addr=0, mem_data=0, latched fields=0.
REQ-023 Reset mid-SCAN SHALL abort the command without issuing further writes or a done pulse.

Configuration
REQ-024 Macro SAND_BRUSH_ROUND_EN defined: candidate is inside iff dx*dx+dy*dy <= r*r (dx=cx-x, dy=cy-y, 17-bit unsigned compare).
REQ-025 Macro SAND_BRUSH_ROUND_EN undefined: every candidate in the clipped box is inside (square brush); no multipliers.

Verification
REQ-026 Accept (10,10,r=0,type=2) -> one write: addr 1610, data 2; done in cycle N+3.
REQ-027 With ROUND_EN, (10,10,r=1,type=1) -> writes to addrs 1450,1609,1610,1611,1770 in that order. Without ROUND_EN -> 9 writes, 1449..1451, 1609..1611, 1769..1771.
REQ-028 With ROUND_EN, (0,0,r=2) -> clipped writes to addrs 0,1,2,160,161,320 only.
REQ-029 (200,50,r=3) -> no mem_we; done in cycle N+2; cmd_ready returns to 1 in the following cycle.
REQ-030 In the (10,10,r=1) case, hold mem_ready=0 for 3 cycles on the first write -> addr 1450 is held for 4 cycles; total write sequence is unchanged.
REQ-031 Assert reset during SCAN after the second write -> no further mem_we and no done; IDLE outputs hold; the next command executes normally.
